spi_pwm_ctrl: RTL
=================

# spi_pwm_ctrl

Byte-level command decoder and PWM register bank that sits directly downstream of the SPI slave byte interface. It consumes received bytes and frame strobes, decodes a one-byte command header, writes or reads a bank of per-channel 8-bit duty registers with address auto-increment, and supplies the next transmit byte back to the SPI slave. It also generates the glitch-free PWM outputs that drive the LEDs.

## Interface
- NCH, 4: number of PWM channels, 1..8.
- PRESCALE, 16: SYSCLK cycles per PWM counter step, ≥1.

- SYSCLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RXD  in  8  received byte from the SPI slave; valid when RXRDY=1.
- RXRDY  in  1  one-cycle pulse: a new byte is on RXD.
- FRAME_START  in  1  one-cycle pulse on the CS falling edge.
- FRAME_END  in  1  one-cycle pulse on the CS rising edge.
- TXD  out  8  registered byte offered to the SPI slave. The slave loads it into its shifter at frame start and at the end of every byte.
- PWM  out  NCH  PWM outputs, active-high, registered.

## Operation
- States: IDLE, CMD, WRITE, READ.
- IDLE:
  - TXD = 8'hA5 (ID byte).
  - RXRDY is ignored.
  - FRAME_START moves to CMD.
- CMD: the first RXRDY of the frame is the command byte.
  - bit7=1 selects read, bit7=0 selects write.
  - bits[2:0] load the 3-bit address pointer PTR.
  - bits[6:3] are ignored.
  - Read: TXD ← duty[PTR], PTR ← PTR+1, go to READ.
  - Write: go to WRITE.
- WRITE: each RXRDY performs duty[PTR] ← RXD, then PTR ← PTR+1.
- READ: each RXRDY performs TXD ← duty[PTR], then PTR ← PTR+1. RXD content is ignored.
- Address rules:
  - PTR wraps 7→0.
  - Addresses ≥ NCH are unmapped: writes there are dropped and reads return 8'h00. PTR still increments.
- FRAME_END from any state: go to IDLE and set TXD ← 8'hA5.
- FRAME_START from any non-IDLE state (CS re-asserted without a seen rising edge): abort the current frame and go to CMD. PTR is not changed until the next command byte.
- RXRDY and FRAME_END in the same cycle: the byte is processed first (a write commits), then the state goes to IDLE.
- RXRDY and FRAME_START in the same cycle: FRAME_START wins and the byte is discarded.
- PWM generation:
  - Prescaler counts 0..PRESCALE-1. At terminal count, the 8-bit counter CNT increments, wrapping 255→0.
  - Each channel has an active register act[i]. PWM[i] ← (CNT < act[i]).
  - act[i] ← duty[i] only on the step where CNT wraps 255→0, so a duty change never truncates or stretches the current period.
  - duty=0 gives constant 0. duty=255 gives high for 255 of 256 steps.

## Timing
- Reset values:
  - state IDLE, PTR 0, TXD 8'hA5
  - all duty and act = 0, CNT 0, prescaler 0, PWM all 0
- Register write latency: duty[PTR] is updated on the SYSCLK edge after the cycle with RXRDY=1.
- TXD update: on the edge after RXRDY, and on the edge after FRAME_END.
- Read data lags by one byte, because the slave loads TXD at the end of a byte, before that byte's RXRDY. For a frame with read command address A, MISO carries:
  - byte 0: 8'hA5
  - byte 1: 8'hA5
  - byte n (n≥2): duty[A+n-2]
- PWM period = 256·PRESCALE SYSCLK cycles.
- PWM[i] changes one SYSCLK after CNT changes.
- A new duty value takes effect at the next CNT wrap: at most 256·PRESCALE+2 cycles after the write.
- Mid-operation reset: all state and outputs return to their reset values immediately (asynchronous). A frame in flight is lost.

## Test plan
- Reset: assert RST mid-frame → TXD=8'hA5, PWM=0, a subsequent read of any channel returns 8'h00.
- Burst write: frame with bytes 8'h01, 8'h40, 8'h80, 8'hFF (NCH=4) → duty[1]=8'h40, duty[2]=8'h80, duty[3]=8'hFF, duty[0] unchanged.
- Burst read after the write above: frame with bytes 8'h81 then 3 dummies → MISO bytes A5, A5, 40, 80.
- Wrap and unmapped: write frame starting at addr 3 with bytes 11, 22, 33, 44, 55, 66 (NCH=4) → duty[3]=11, addresses 4–7 dropped, duty[0]=66. Reading from addr 6 returns 00, 00, then duty[0].
- PWM duty with PRESCALE=1, duty[0]=8'h40 → PWM[0] high for exactly 64 of 256 cycles per period. A write to 8'hC0 mid-period → the current period is still 64 high and the next is 192 high. duty=0 gives constant 0.
- Frame events:
  - FRAME_END coincident with the RXRDY of a data byte → the write is committed and the state returns to IDLE.
  - FRAME_START during WRITE → the next byte is decoded as a command.
  - RXRDY in IDLE → no register change.

Source files
------------

// File: rtl/spi_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// spi_pwm_ctrl
//   Command decoder and PWM register bank behind an SPI slave byte interface.
//   The first byte of a frame is a command: bit7 selects read (1) or write (0),
//   and bits[2:0] load the address pointer. Each following byte writes a duty
//   register, or returns the next one on TXD. The pointer increments after
//   every data byte and wraps 7->0. Addresses >= NCH are unmapped: writes are
//   dropped and reads return 0.
//   Each channel drives a PWM output. A free-running 8-bit counter advances
//   every PRESCALE clocks. New duty values are latched only when the counter
//   wraps, so a period is never cut short or stretched by a write.
//
// Ports
//   SYSCLK       system clock, rising edge
//   RST          asynchronous active-high reset
//   RXD[7:0]     received byte, valid with RXRDY
//   RXRDY        one-cycle strobe for RXD
//   FRAME_START  one-cycle strobe on CS falling edge
//   FRAME_END    one-cycle strobe on CS rising edge
//   TXD[7:0]     registered byte that the slave loads for transmission
//   PWM[NCH-1:0] registered active-high PWM outputs
// ---------------------------------------------------------------------------

// One PWM channel. The active compare value is reloaded from duty only on the
// counter wrap.
module pwm_lane (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic [7:0] duty,
    input  logic [7:0] cnt,
    input  logic       wrap,
    output logic       pwm
);
    logic [7:0] act;

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            act <= 8'h00;
            pwm <= 1'b0;
        end else begin
            if (wrap) act <= duty;
            // Compare against the counter value before this edge. The output
            // therefore trails the counter by one clock. Because act only
            // changes when cnt goes 255->0, each period uses one value.
            pwm <= (cnt < act);
        end
    end
endmodule

module spi_pwm_ctrl #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 16
) (
    input  logic           SYSCLK,
    input  logic           RST,
    input  logic [7:0]     RXD,
    input  logic           RXRDY,
    input  logic           FRAME_START,
    input  logic           FRAME_END,
    output logic [7:0]     TXD,
    output logic [NCH-1:0] PWM
);
    localparam logic [7:0] ID_BYTE = 8'hA5;
    localparam logic [3:0] NCH_W   = 4'(NCH);
    localparam int         PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t          state;
    logic [2:0]      ptr;
    logic [7:0][7:0] duty;   // only entries below NCH are ever written
    logic [7:0]      cnt;
    logic            step;
    logic            wrap;

    // Read sources: the command address for the first read byte, and the
    // running pointer for later ones.
    logic [2:0] cmd_addr;
    logic       cmd_mapped;
    logic       ptr_mapped;
    logic [7:0] cmd_rd;
    logic [7:0] ptr_rd;

    always_comb begin
        cmd_addr   = RXD[2:0];
        cmd_mapped = ({1'b0, cmd_addr} < NCH_W);
        ptr_mapped = ({1'b0, ptr} < NCH_W);
        cmd_rd     = cmd_mapped ? duty[cmd_addr] : 8'h00;
        ptr_rd     = ptr_mapped ? duty[ptr]      : 8'h00;
    end

    // -----------------------------------------------------------------------
    // Frame / command FSM. It owns the pointer, the duty bank and TXD.
    // Priority: FRAME_START aborts and discards any coincident byte.
    // Otherwise, a byte is processed first and FRAME_END then returns to IDLE.
    // A write that coincides with FRAME_END still commits.
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 3'd0;
            TXD   <= ID_BYTE;
            duty  <= '0;
        end else begin
            if (FRAME_START) begin
                // PTR stays unchanged until the next command byte.
                state <= CMD;
            end else begin
                if (RXRDY) begin
                    case (state)
                        CMD: begin
                            if (RXD[7]) begin
                                TXD   <= cmd_rd;
                                ptr   <= cmd_addr + 3'd1;
                                state <= READ;
                            end else begin
                                ptr   <= cmd_addr;
                                state <= WRITE;
                            end
                        end
                        WRITE: begin
                            if (ptr_mapped) duty[ptr] <= RXD;
                            ptr <= ptr + 3'd1;
                        end
                        READ: begin
                            TXD <= ptr_rd;
                            ptr <= ptr + 3'd1;
                        end
                        default: ;  // IDLE ignores bytes outside a frame
                    endcase
                end
                if (FRAME_END) begin
                    state <= IDLE;
                    TXD   <= ID_BYTE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // PWM timebase: prescaler -> 8-bit step counter
    // -----------------------------------------------------------------------
    if (PRESCALE > 1) begin : g_presc
        logic [PW-1:0] presc;
        assign step = (presc == PW'(PRESCALE - 1));
        always_ff @(posedge SYSCLK or posedge RST) begin
            if (RST)       presc <= '0;
            else if (step) presc <= '0;
            else           presc <= presc + 1'b1;
        end
    end else begin : g_nopresc
        assign step = 1'b1;
    end

    assign wrap = step && (cnt == 8'hFF);

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST)       cnt <= 8'h00;
        else if (step) cnt <= cnt + 8'd1;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        pwm_lane u_lane (
            .SYSCLK (SYSCLK),
            .RST    (RST),
            .duty   (duty[i]),
            .cnt    (cnt),
            .wrap   (wrap),
            .pwm    (PWM[i])
        );
    end
endmodule
